// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator call scheduler.
package elevator_pkg;

  localparam int DEFAULT_NUM_FLOORS = 7;
  localparam int FLOOR_W = 3;

  // Step commands understood by the floor-position counter.
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;
  localparam logic [1:0] DIR_HOLD = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } state_t;

endpackage

// File: rtl/elevator_scheduler_if.sv
// Button/counter/display bundle between the scheduler and its surroundings.
interface elevator_scheduler_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS
);
  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    floor;
  logic [1:0]            dir;
  logic                  door_open;
  logic                  moving;
  logic [NUM_FLOORS-1:0] pending;

  // Environment side: buttons and position counter drive, it observes the rest.
  modport master (
    output call_req, floor,
    input  dir, door_open, moving, pending
  );

  // Scheduler side.
  modport slave (
    input  call_req, floor,
    output dir, door_open, moving, pending
  );
endinterface

// File: rtl/elevator_scheduler_call_scanner.sv
// Splits the latched calls into those above and below the car.
// An out-of-range floor matches nothing, so every output is zero then.
module call_scanner
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  output logic [NUM_FLOORS-1:0] here_onehot,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  at_call,
  output logic                  floor_valid
);
  logic [NUM_FLOORS-1:0] above;
  logic [NUM_FLOORS-1:0] below;

  assign floor_valid = (32'(floor) < NUM_FLOORS);

  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      assign here_onehot[gi] = (32'(floor) == gi);
      assign above[gi] = pending[gi] && floor_valid && (gi > 32'(floor));
      assign below[gi] = pending[gi] && floor_valid && (gi < 32'(floor));
    end
  endgenerate

  assign any_above = |above;
  assign any_below = |below;
  assign at_call   = |(pending & here_onehot);
endmodule

// File: rtl/elevator_scheduler.sv
// Collective (SCAN) call scheduler: latches calls, pulses one-floor steps
// to the position counter and times the door dwell at each served floor.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = DEFAULT_NUM_FLOORS,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 4
) (
  input logic                 clk,
  input logic                 reset,
  elevator_scheduler_if.slave bus
);
  localparam int ST_W = $clog2(MOVE_CYCLES);
  localparam int DT_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [ST_W-1:0] STEP_LAST = ST_W'(MOVE_CYCLES - 1);
  localparam logic [DT_W-1:0] DOOR_LAST = DT_W'(DOOR_CYCLES - 1);

  state_t                state_reg;
  logic [ST_W-1:0]       step_timer_reg;
  logic [DT_W-1:0]       door_timer_reg;
  logic                  last_up_reg;
  logic [NUM_FLOORS-1:0] pending_reg;

  logic [NUM_FLOORS-1:0] here_onehot;
  logic [NUM_FLOORS-1:0] pending_next;
  logic any_above, any_below, at_call, floor_valid;
  logic door_hold, ahead;

  call_scanner #(.NUM_FLOORS(NUM_FLOORS)) u_scanner (
    .pending     (pending_reg),
    .floor       (bus.floor),
    .here_onehot (here_onehot),
    .any_above   (any_above),
    .any_below   (any_below),
    .at_call     (at_call),
    .floor_valid (floor_valid)
  );

  // New calls to latch; a press at the floor whose door is open only holds the door.
  always_comb begin
    door_hold    = (state_reg == DOOR_OPEN) && (|(bus.call_req & here_onehot));
    pending_next = pending_reg | bus.call_req;
    if (state_reg == DOOR_OPEN) begin
      pending_next = pending_reg | (bus.call_req & ~here_onehot);
    end
    ahead = (state_reg == MOVE_UP) ? any_above : any_below;
  end

  // Scheduler FSM: state, timers, direction memory and latched calls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      step_timer_reg <= '0;
      door_timer_reg <= '0;
      last_up_reg    <= 1'b1;
      pending_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      if (!floor_valid) begin
        // Position unknown: park until the counter reports a real floor.
        state_reg      <= IDLE;
        step_timer_reg <= '0;
        door_timer_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (at_call) begin
              state_reg      <= DOOR_OPEN;
              door_timer_reg <= '0;
              pending_reg    <= pending_next & ~here_onehot;
            end else if (any_above && (last_up_reg || !any_below)) begin
              state_reg      <= MOVE_UP;
              step_timer_reg <= '0;
              last_up_reg    <= 1'b1;
            end else if (any_below) begin
              state_reg      <= MOVE_DOWN;
              step_timer_reg <= '0;
              last_up_reg    <= 1'b0;
            end
          end
          MOVE_UP, MOVE_DOWN: begin
            // Stop decisions are made only at timer 0, once the new floor is visible.
            if (step_timer_reg == '0 && at_call) begin
              state_reg      <= DOOR_OPEN;
              door_timer_reg <= '0;
              pending_reg    <= pending_next & ~here_onehot;
            end else if (step_timer_reg == '0 && !ahead) begin
              // Nothing left in this direction: never step past the last call.
              state_reg <= IDLE;
            end else if (step_timer_reg == STEP_LAST) begin
              step_timer_reg <= '0;
            end else begin
              step_timer_reg <= step_timer_reg + ST_W'(1);
            end
          end
          DOOR_OPEN: begin
            if (door_hold) begin
              door_timer_reg <= '0;
            end else if (door_timer_reg == DOOR_LAST) begin
              state_reg      <= IDLE;
              door_timer_reg <= '0;
            end else begin
              door_timer_reg <= door_timer_reg + DT_W'(1);
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Step pulse decoded from registered state only: one cycle per floor.
  always_comb begin
    bus.dir = DIR_HOLD;
    if (step_timer_reg == STEP_LAST) begin
      if (state_reg == MOVE_UP) begin
        bus.dir = DIR_UP;
      end else if (state_reg == MOVE_DOWN) begin
        bus.dir = DIR_DOWN;
      end
    end
  end

  assign bus.door_open = (state_reg == DOOR_OPEN);
  assign bus.moving    = (state_reg == MOVE_UP) || (state_reg == MOVE_DOWN);
  assign bus.pending   = pending_reg;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench: directed scenarios plus a long random run, compared
// every cycle against a behavioural elevator model that also drives the floor.
module tb_elevator_scheduler;
  localparam int NF = 7;
  localparam int MC = 4;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  elevator_scheduler_if #(.NUM_FLOORS(NF)) bus ();

  elevator_scheduler #(
    .NUM_FLOORS (NF),
    .MOVE_CYCLES(MC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [NF-1:0] call_drv = '0;
  logic force_invalid = 1'b0;
  int start_floor = 0;
  int pos = 0;  // car position held by the bench's floor counter

  assign bus.call_req = call_drv;
  assign bus.floor    = force_invalid ? 3'd7 : 3'(pos);

  // Behavioural model: mode plus cycles spent in it, and a plain set of calls.
  typedef enum {M_IDLE, M_UP, M_DOWN, M_DOOR} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_elapsed = 0;
  bit    m_pend[NF];
  bit    m_last_up = 1'b1;
  bit    cmp_en = 1'b0;

  function automatic logic [1:0] exp_dir();
    if (m_mode == M_UP && (m_elapsed % MC) == MC - 1) return 2'b10;
    if (m_mode == M_DOWN && (m_elapsed % MC) == MC - 1) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [NF-1:0] exp_pend();
    logic [NF-1:0] v;
    for (int i = 0; i < NF; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model advance at each clock edge, including the bench's floor counter.
  always @(posedge clk) begin
    mode_t nm;
    int    ne, f;
    bit    np[NF];
    bit    nl, valid, ab, be;
    logic [1:0] d;
    if (reset) begin
      m_mode    <= M_IDLE;
      m_elapsed <= 0;
      for (int i = 0; i < NF; i++) np[i] = 1'b0;
      m_pend    <= np;
      m_last_up <= 1'b1;
      pos       <= start_floor;
      cmp_en    <= 1'b1;
    end else begin
      d = exp_dir();
      f = force_invalid ? 7 : pos;
      valid = (f < NF);
      nm = m_mode; ne = m_elapsed; nl = m_last_up; np = m_pend;
      ab = 1'b0; be = 1'b0;
      for (int i = 0; i < NF; i++) begin
        if (call_drv[i] && !(m_mode == M_DOOR && i == f)) np[i] = 1'b1;
        if (valid && m_pend[i] && i > f) ab = 1'b1;
        if (valid && m_pend[i] && i < f) be = 1'b1;
      end
      if (!valid) begin
        nm = M_IDLE; ne = 0;
      end else begin
        case (m_mode)
          M_IDLE: begin
            if (m_pend[f]) begin nm = M_DOOR; ne = 0; np[f] = 1'b0; end
            else if (ab && (m_last_up || !be)) begin nm = M_UP; ne = 0; nl = 1'b1; end
            else if (be) begin nm = M_DOWN; ne = 0; nl = 1'b0; end
          end
          M_UP, M_DOWN: begin
            if ((m_elapsed % MC) == 0 && m_pend[f]) begin nm = M_DOOR; ne = 0; np[f] = 1'b0; end
            else ne = m_elapsed + 1;
          end
          default: begin
            if (call_drv[f]) ne = 0;
            else if (m_elapsed == DC - 1) begin nm = M_IDLE; ne = 0; end
            else ne = m_elapsed + 1;
          end
        endcase
      end
      m_mode    <= nm;
      m_elapsed <= ne;
      m_last_up <= nl;
      m_pend    <= np;
      if (d == 2'b10) pos <= pos + 1;
      else if (d == 2'b01) pos <= pos - 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("dir", 32'(bus.dir), 32'(exp_dir()));
      check("door_open", 32'(bus.door_open), 32'(m_mode == M_DOOR));
      check("moving", 32'(bus.moving), 32'(m_mode == M_UP || m_mode == M_DOWN));
      check("pending", 32'(bus.pending), 32'(exp_pend()));
      check("no_up_at_top", 32'(bus.dir == 2'b10 && bus.floor == 3'(NF - 1)), 32'd0);
      check("no_down_at_0", 32'(bus.dir == 2'b01 && bus.floor == 3'd0), 32'd0);
    end
  end

  // Reset with the counter loaded to fl; returns at the first post-reset negedge.
  task automatic do_reset(int fl);
    @(negedge clk);
    reset = 1'b1; start_floor = fl; call_drv = '0; force_invalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int served[$];
    int door_cnt, dir_cnt, first_close, first_down, cyc;
    logic prev_door;

    // Reset while calls are arriving.
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      call_drv = NF'($urandom_range(0, (1 << NF) - 1));
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_dir", 32'(bus.dir), 32'd0);
    check("rst_door", 32'(bus.door_open), 32'd0);
    check("rst_moving", 32'(bus.moving), 32'd0);
    call_drv = '0;

    // Single call from floor 0 to floor 2, cycle-exact.
    do_reset(0);
    call_drv = 7'b0000100;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      call_drv = '0;
      check($sformatf("single_dir_c%0d", k), 32'(bus.dir), (k == 5 || k == 9) ? 32'd2 : 32'd0);
      check($sformatf("single_moving_c%0d", k), 32'(bus.moving), 32'(k >= 2 && k <= 10));
      check($sformatf("single_door_c%0d", k), 32'(bus.door_open), 32'(k >= 11 && k <= 14));
      check($sformatf("single_pend_c%0d", k), 32'(bus.pending), (k < 11) ? 32'h04 : 32'h00);
      if (k == 10) check("single_floor_c10", 32'(bus.floor), 32'd2);
    end

    // SCAN order: at floor 3 going up, floor 5 is served before floor 1.
    do_reset(3);
    call_drv = 7'b0100010;
    prev_door = 1'b0; first_close = -1; first_down = -1;
    for (cyc = 1; cyc < 200 && served.size() < 2; cyc++) begin
      @(negedge clk);
      call_drv = '0;
      if (bus.door_open && !prev_door) served.push_back(int'(bus.floor));
      if (!bus.door_open && prev_door && first_close < 0) first_close = cyc;
      if (bus.dir == 2'b01 && first_down < 0) first_down = cyc;
      prev_door = bus.door_open;
    end
    check("scan_served_count", 32'(served.size()), 32'd2);
    if (served.size() == 2) begin
      check("scan_first", 32'(served[0]), 32'd5);
      check("scan_second", 32'(served[1]), 32'd1);
    end
    check("scan_down_after_close", 32'(first_down > first_close && first_close > 0), 32'd1);

    // Boundary floors: a call at the car's own floor opens the door without stepping.
    for (int b = 0; b < 2; b++) begin
      do_reset(b == 0 ? NF - 1 : 0);
      call_drv = '0;
      call_drv[b == 0 ? NF - 1 : 0] = 1'b1;
      door_cnt = 0; dir_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        call_drv = '0;
        if (bus.door_open) door_cnt++;
        if (bus.dir != 2'b00) dir_cnt++;
      end
      check($sformatf("bound%0d_door_cycles", b), 32'(door_cnt), 32'd4);
      check($sformatf("bound%0d_steps", b), 32'(dir_cnt), 32'd0);
    end

    // Door-hold: a press at the open floor in the second door cycle restarts the dwell.
    do_reset(3);
    call_drv = 7'b0001000;
    door_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.door_open) door_cnt++;
      call_drv = (k == 3) ? 7'b0001000 : 7'b0000000;
    end
    check("hold_door_cycles", 32'(door_cnt), 32'd6);
    check("hold_not_latched", 32'(bus.pending), 32'd0);

    // Invalid floor: park with calls latched, resume once the floor is valid.
    do_reset(0);
    force_invalid = 1'b1;
    call_drv = 7'b0010000;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      call_drv = '0;
      check("inv_dir", 32'(bus.dir), 32'd0);
      check("inv_moving", 32'(bus.moving), 32'd0);
    end
    check("inv_pending", 32'(bus.pending), 32'h10);
    force_invalid = 1'b0;
    door_cnt = 0;
    for (int k = 0; k < 100 && door_cnt == 0; k++) begin
      @(negedge clk);
      if (bus.door_open && bus.floor == 3'd4) door_cnt = 1;
    end
    check("inv_resume_served", 32'(door_cnt), 32'd1);

    // Long random run with sparse calls, occasional resets and invalid-floor windows.
    do_reset($urandom_range(0, NF - 1));
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      call_drv = '0;
      if ($urandom_range(0, 3) == 0) call_drv[$urandom_range(0, NF - 1)] = 1'b1;
      force_invalid = ((k % 1000) >= 500 && (k % 1000) < 506);
      start_floor = pos;
      reset = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    call_drv = '0;
    force_invalid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Elevator call scheduler that sequences the floor-position counter. It latches hall/car calls for 7 floors and drives the counter's 2-bit direction input with single-cycle step pulses. It follows a collective (SCAN) policy: it keeps the current direction while calls remain ahead, then reverses. It also times the door-open dwell at each served floor and sits between the button inputs and the floor counter/display path.

## Interface
- NUM_FLOORS, 7, number of floors; floors are indexed 0..NUM_FLOORS-1.
- MOVE_CYCLES, 4, clock cycles per one-floor step; must be ≥2.
- DOOR_CYCLES, 4, clock cycles the door stays open; must be ≥1.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- call_req  in  NUM_FLOORS  call buttons, one bit per floor, sampled every cycle; a level or a pulse are treated the same.
- floor  in  3  current floor from the position counter's count output.
- dir  out  2  step command to the counter: 2'b10 = up one floor, 2'b01 = down one floor, 2'b00 = hold.
- door_open  out  1  high while the door is open.
- moving  out  1  high in the MOVE_UP and MOVE_DOWN states.
- pending  out  NUM_FLOORS  latched, unserved calls.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- The block holds a last_dir register: up or down.
- Latching calls: pending[f] is set at the edge after call_req[f]=1.
  - Exception: a call to the current floor while in DOOR_OPEN is not latched. It restarts the door timer at 0 instead (door-hold).
- Masks: above = pending bits for floors greater than floor; below = pending bits for floors less than floor.

State transitions:
- IDLE:
  - pending[floor]=1 → DOOR_OPEN.
  - else, above≠0 and (last_dir=up or below=0) → MOVE_UP, last_dir=up.
  - else, below≠0 → MOVE_DOWN, last_dir=down.
  - else stay in IDLE.
- MOVE_x: step_timer counts 0..MOVE_CYCLES-1.
  - When timer=0, if pending[floor]=1 → DOOR_OPEN.
  - When timer=MOVE_CYCLES-1, dir=DIR_UP (in MOVE_UP) or DIR_DOWN (in MOVE_DOWN), then the timer wraps to 0.
- DOOR_OPEN: door_timer counts 0..DOOR_CYCLES-1; when it reaches DOOR_CYCLES-1 → IDLE.

Required behaviour:
- The block never issues up at floor NUM_FLOORS-1 or down at floor 0. The counter's wrap-around is therefore never exercised.
- If floor ≥ NUM_FLOORS: no mask bit matches, so the state goes to IDLE and dir=00. The block holds there until floor is valid again.
- Simultaneous set and clear: if call_req[f] arrives on the same edge that pending[f] is cleared by a DOOR_OPEN entry, the clear wins.
- A call to the current floor arriving while MOVE timer>0 is latched and served on the return pass.

## Timing
- Reset values, at the edge after reset=1:
  - state=IDLE, pending=0, last_dir=up, both timers=0.
  - dir=00, door_open=0, moving=0.
- Reset mid-move: everything clears on the next edge and no further step is issued. The counter is reset independently.
- dir, door_open and moving are decoded from registered state and timers only. There is no combinational path from input to output.
- dir is non-zero for exactly one cycle per step. The counter updates floor at that edge, and the new floor is seen when timer=0.
- Cycle costs:
  - Call latch: 1 cycle.
  - IDLE decision: 1 cycle.
  - Per floor travel: MOVE_CYCLES cycles.
  - Door: DOOR_CYCLES cycles, then 1 cycle in IDLE before the next move.
- pending[floor] is cleared on the edge that enters DOOR_OPEN.

## Structure
- elevator_pkg holds:
  - The state enum.
  - DIR_UP=2'b10, DIR_DOWN=2'b01, DIR_HOLD=2'b00.
  - Default NUM_FLOORS.
- Sub-module call_scanner: combinational; produces the above/below masks and any_above/any_below from pending and floor; treats out-of-range floor as no match.
- The top level holds the state register, the two timers, last_dir and the pending register.

## Test plan
All scenarios use MOVE_CYCLES=4 and DOOR_CYCLES=4 unless stated.
- Reset: drive random call_req, then assert reset → pending=0, dir=00, door_open=0, state IDLE on the next cycle.
- Single call: floor=0, call_req[2] pulsed in cycle 0.
  - pending[2]=1 in cycle 1; moving=1 from cycle 2.
  - dir=10 in cycles 5 and 9; floor=2 in cycle 10.
  - door_open=1 in cycles 11–14; pending=0 from cycle 11; IDLE in cycle 15.
- SCAN order: at floor 3, calls for floors 5 and 1 arrive with last_dir=up → floor 5 is served before floor 1; dir=01 only after floor 5's door closes.
- Boundaries: at floor 6 with call 6, and at floor 0 with call 0 → door opens and dir stays 00. Over a long random run, assert dir=10 never occurs at floor 6 and dir=01 never occurs at floor 0.
- Door-hold: call_req[floor] pulsed in door cycle 2 → door_open lasts 2+4 cycles in total; the call is not latched.
- Invalid floor: floor=7 with calls pending → dir=00 and state IDLE. Restoring floor=0 resumes service.
